// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator between the memory stage and a
// word-wide data memory. One request in flight at a time. Sub-word stores are
// done as read-modify-write. Misaligned, illegal-size and out-of-range requests
// are answered with an error and never touch memory.
// Optional: define LSU_TRACE_EN to print every committed word write.
module lsu_mem_initiator #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WRITE,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        req_err;

    // Replace the addressed lane of a word with right-justified store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (size == 2'b00)      r[{off, 3'b000} +: 8]     = wd[7:0];
        else if (size == 2'b01) r[{off[1], 4'b0000} +: 16] = wd[15:0];
        else                    r = wd;
        return r;
    endfunction

    // Pick the addressed lane out of a word and sign/zero extend it.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [31:0] b, h;
        b = word >> {off, 3'b000};
        h = word >> {off[1], 4'b0000};
        if (size == 2'b00)
            return uns ? {24'b0, b[7:0]} : {{24{b[7]}}, b[7:0]};
        else if (size == 2'b01)
            return uns ? {16'b0, h[15:0]} : {{16{h[15]}}, h[15:0]};
        else
            return word;
    endfunction

    // Reject illegal size, misalignment and addresses beyond the memory.
    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]))
                   | (req_addr >= 32'(MEM_BYTES));

    // Next-state and next-output logic; outputs are decoded from the next state
    // so every strobe comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    if (req_err) begin
                        state_d     = S_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_we && req_size == 2'b10) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (we_q) begin
                    state_d     = S_WRITE;
                    mem_wdata_d = merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                end else begin
                    state_d     = S_RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = extract_lane(mem_rdata, size_q, addr_q[1:0], uns_q);
                end
            end
            S_WRITE: begin
                state_d     = S_RESP;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        mem_re_d    = (state_d == S_RD_ISSUE);
        mem_we_d    = (state_d == S_WRITE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;

`ifdef LSU_TRACE_EN
    // Print each committed word write with the merged data.
    always_ff @(posedge clk) begin
        if (reset && mem_we_q)
            $display("@%h: *%h <= %h", pc_q, mem_addr, mem_wdata);
    end
`else
    // PC is only consumed by the trace.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

endmodule
